// File: rtl/pcm_prefetch_if.sv
// PCM prefetch bus bundle: SDRAM arbiter read port plus I2S sample FIFO port.
//   sdram_addr   : read word address (controller -> arbiter)
//   sdram_rd     : read request, held until sdram_ac (controller -> arbiter)
//   sdram_wait   : arbiter not granting the PCM port (arbiter -> controller)
//   sdram_ac     : 1-cycle acknowledge, sdram_rddata valid (arbiter -> controller)
//   sdram_rddata : read data (arbiter -> controller)
//   sample_req   : pop FIFO head (serializer -> controller)
//   sample_valid : FIFO not empty (controller -> serializer)
//   sample_data  : FIFO head word, show-ahead (controller -> serializer)
// master = the prefetch controller, slave = arbiter/serializer side.
interface pcm_prefetch_if #(
   parameter int unsigned ADDR_W = 25
);
   logic [ADDR_W-1:0] sdram_addr;
   logic              sdram_rd;
   logic              sdram_wait;
   logic              sdram_ac;
   logic [15:0]       sdram_rddata;
   logic              sample_req;
   logic              sample_valid;
   logic [15:0]       sample_data;

   modport master (
      output sdram_addr, sdram_rd, sample_valid, sample_data,
      input  sdram_wait, sdram_ac, sdram_rddata, sample_req
   );

   modport slave (
      input  sdram_addr, sdram_rd, sample_valid, sample_data,
      output sdram_wait, sdram_ac, sdram_rddata, sample_req
   );
endinterface

// File: rtl/pcm_prefetch_ctrl.sv
// PCM prefetch controller: walks an SDRAM sample region (one-shot or looped)
// and keeps a small show-ahead FIFO topped up ahead of the I2S serializer.
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   start, stop         : 1-cycle control pulses (stop wins)
//   loop_en             : restart at base when region ends (sampled at start)
//   base_addr, num_words: region description (latched at start)
//   bus (master)        : SDRAM read port and sample FIFO port
//   busy, done, underrun: status (done is a 1-cycle pulse, underrun sticky)
module pcm_prefetch_ctrl #(
   parameter int unsigned ADDR_W    = 25,
   parameter int unsigned DEPTH     = 16,
   parameter int unsigned LOW_WATER = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              stop,
   input  logic              loop_en,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W-1:0] num_words,
   pcm_prefetch_if.master    bus,
   output logic              busy,
   output logic              done,
   output logic              underrun
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_REFILL,
      ST_DRAIN,
      ST_DONE
   } state_t;

   state_t            state;
   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W-1:0] base_q;
   logic [ADDR_W-1:0] num_q;
   logic              loop_q;
   logic [ADDR_W-1:0] remaining_q;
   logic              rd_q;

   logic [15:0]       mem [DEPTH];
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  wr_ptr;
   logic [CNT_W-1:0]  count;
   logic              valid_q;
   logic [15:0]       data_q;

   logic              push;
   logic              pop;
   logic              underrun_hit;
   logic [CNT_W-1:0]  count_after_pop;
   logic [CNT_W-1:0]  count_nx;
   logic [PTR_W-1:0]  rd_ptr_nx;
   logic [PTR_W-1:0]  wr_ptr_nx;
   logic [15:0]       head_nx;

   assign bus.sdram_addr   = addr_q;
   assign bus.sdram_rd     = rd_q;
   assign bus.sample_valid = valid_q;
   assign bus.sample_data  = data_q;

   // FIFO next state; the head word is precomputed so sample_data is a flop.
   always_comb begin
      push            = (state == ST_FETCH) && rd_q && bus.sdram_ac;
      pop             = bus.sample_req && (count != '0);
      underrun_hit    = bus.sample_req && (count == '0) &&
                        ((state == ST_FETCH) || (state == ST_REFILL));
      count_after_pop = count - CNT_W'(pop);
      count_nx        = count_after_pop + CNT_W'(push);
      rd_ptr_nx       = rd_ptr + PTR_W'(pop);
      wr_ptr_nx       = wr_ptr + PTR_W'(push);
      head_nx         = 16'h0;
      if (stop) begin
         count_nx  = '0;
         rd_ptr_nx = '0;
         wr_ptr_nx = '0;
      end else if (count_nx != '0) begin
         // A word landing in an (effectively) empty FIFO becomes the head directly.
         if (push && (count_after_pop == '0)) head_nx = bus.sdram_rddata;
         else                                 head_nx = mem[rd_ptr_nx];
      end
   end

   // FIFO storage (no reset needed; validity tracked by count)
   always_ff @(posedge clk) begin
      if (push && !stop) mem[wr_ptr] <= bus.sdram_rddata;
   end

   // FIFO pointers, count and registered head
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count   <= '0;
         valid_q <= 1'b0;
         data_q  <= 16'h0;
      end else begin
         rd_ptr  <= rd_ptr_nx;
         wr_ptr  <= wr_ptr_nx;
         count   <= count_nx;
         valid_q <= (count_nx != '0);
         data_q  <= head_nx;
      end
   end

   // Playback sequencer with registered read request and status outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= ST_IDLE;
         addr_q      <= '0;
         base_q      <= '0;
         num_q       <= '0;
         loop_q      <= 1'b0;
         remaining_q <= '0;
         rd_q        <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         underrun    <= 1'b0;
      end else begin
         done <= 1'b0;
         if (underrun_hit) underrun <= 1'b1;
         if (stop) begin
            state <= ST_IDLE;
            rd_q  <= 1'b0;
            busy  <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (start) begin
                     base_q      <= base_addr;
                     num_q       <= num_words;
                     loop_q      <= loop_en;
                     addr_q      <= base_addr;
                     remaining_q <= num_words;
                     underrun    <= 1'b0;
                     busy        <= 1'b1;
                     if (num_words == '0) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                     end else begin
                        state <= ST_FETCH;
                     end
                  end
               end

               ST_FETCH: begin
                  if (rd_q) begin
                     if (bus.sdram_ac) begin
                        rd_q <= 1'b0;
                        if (remaining_q == ADDR_W'(1)) begin
                           if (loop_q) begin
                              addr_q      <= base_q;
                              remaining_q <= num_q;
                              if (count_nx == CNT_W'(DEPTH)) state <= ST_REFILL;
                           end else begin
                              addr_q      <= addr_q + ADDR_W'(1);
                              remaining_q <= '0;
                              state       <= ST_DRAIN;
                           end
                        end else begin
                           addr_q      <= addr_q + ADDR_W'(1);
                           remaining_q <= remaining_q - ADDR_W'(1);
                           if (count_nx == CNT_W'(DEPTH)) state <= ST_REFILL;
                        end
                     end else if (bus.sdram_wait) begin
                        // Grant withdrawn: cancel and reissue the same address later.
                        rd_q <= 1'b0;
                     end
                  end else if (!bus.sdram_wait && (remaining_q != '0) &&
                               (count < CNT_W'(DEPTH))) begin
                     rd_q <= 1'b1;
                  end
               end

               ST_REFILL: begin
                  if (count <= CNT_W'(LOW_WATER)) state <= ST_FETCH;
               end

               ST_DRAIN: begin
                  if (count == '0) begin
                     state <= ST_DONE;
                     done  <= 1'b1;
                  end
               end

               ST_DONE: begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end

               default: begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pcm_prefetch_ctrl.sv
// Directed bench for pcm_prefetch_ctrl with a 3-cycle-latency SDRAM responder.
module tb_pcm_prefetch_ctrl;
   localparam int unsigned ADDR_W = 25;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              start = 1'b0;
   logic              stop = 1'b0;
   logic              loop_en = 1'b0;
   logic [ADDR_W-1:0] base_addr = '0;
   logic [ADDR_W-1:0] num_words = '0;
   logic              busy;
   logic              done;
   logic              underrun;

   pcm_prefetch_if #(.ADDR_W(ADDR_W)) bus ();

   pcm_prefetch_ctrl #(.ADDR_W(ADDR_W), .DEPTH(16), .LOW_WATER(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .stop      (stop),
      .loop_en   (loop_en),
      .base_addr (base_addr),
      .num_words (num_words),
      .bus       (bus),
      .busy      (busy),
      .done      (done),
      .underrun  (underrun)
   );

   always #5 clk = ~clk;

   int n_pass = 0;
   int n_fail = 0;

   logic              ack_en = 1'b0;
   int                inj_req = 0;
   int                inj_done = 0;
   int                n_acks = 0;
   int                done_cnt = 0;
   logic [ADDR_W-1:0] issued [$];

   // Arbiter model: acks 3 cycles into an ungated request, data = low address bits.
   initial begin
      int   lat_cnt;
      logic rd_prev;
      lat_cnt = 0;
      rd_prev = 1'b0;
      forever begin
         @(negedge clk);
         bus.sdram_ac = 1'b0;
         if (done) done_cnt++;
         if (bus.sdram_rd && !rd_prev) issued.push_back(bus.sdram_addr);
         rd_prev = bus.sdram_rd;
         if (inj_req != inj_done) begin
            bus.sdram_ac     = 1'b1;
            bus.sdram_rddata = 16'hBEEF;
            inj_done++;
         end else if (ack_en && bus.sdram_rd && !bus.sdram_wait) begin
            lat_cnt++;
            if (lat_cnt == 3) begin
               bus.sdram_ac     = 1'b1;
               bus.sdram_rddata = 16'(bus.sdram_addr);
               lat_cnt          = 0;
               n_acks++;
            end
         end else begin
            lat_cnt = 0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] n, input logic l);
      base_addr = b;
      num_words = n;
      loop_en   = l;
      start     = 1'b1;
      step();
      start     = 1'b0;
   endtask

   task automatic do_stop();
      stop = 1'b1;
      step();
      stop = 1'b0;
   endtask

   task automatic wait_acks(input int target, input int budget, input string tag);
      int k = 0;
      while ((n_acks < target) && (k < budget)) begin
         step();
         k++;
      end
      check(tag, 32'(n_acks >= target), 1);
   endtask

   task automatic wait_rd(input int budget, input string tag);
      int k = 0;
      while (!bus.sdram_rd && (k < budget)) begin
         step();
         k++;
      end
      check(tag, 32'(bus.sdram_rd), 1);
   endtask

   task automatic wait_idle(input int budget, input string tag);
      int k = 0;
      while (busy && (k < budget)) begin
         step();
         k++;
      end
      check(tag, 32'(busy), 0);
   endtask

   task automatic pop_word(input logic [15:0] exp, input string tag);
      check({tag, "_valid"}, 32'(bus.sample_valid), 1);
      check({tag, "_data"}, 32'(bus.sample_data), 32'(exp));
      bus.sample_req = 1'b1;
      step();
      bus.sample_req = 1'b0;
   endtask

   initial begin
      int i0;
      int a0;
      int d0;
      logic [ADDR_W-1:0] exp_seq [6];

      bus.sdram_wait = 1'b0;
      bus.sample_req = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_rd", 32'(bus.sdram_rd), 0);
      check("rst_addr", 32'(bus.sdram_addr), 0);
      check("rst_valid", 32'(bus.sample_valid), 0);
      check("rst_data", 32'(bus.sample_data), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_underrun", 32'(underrun), 0);
      reset = 1'b0;
      step();

      // One-shot fill of 4 words at 0x100, then drain
      ack_en = 1'b1;
      i0 = issued.size();
      a0 = n_acks;
      do_start(25'h100, 25'd4, 1'b0);
      check("t1_busy", 32'(busy), 1);
      check("t1_rd_lat1", 32'(bus.sdram_rd), 0);
      step();
      check("t1_rd_lat2", 32'(bus.sdram_rd), 1);
      check("t1_first_addr", 32'(bus.sdram_addr), 32'h100);
      wait_acks(a0 + 4, 60, "t1_acks");
      step();
      step();
      check("t1_nreads", 32'(issued.size() - i0), 4);
      for (int i = 0; i < 4; i++)
         check($sformatf("t1_addr%0d", i), 32'(issued[i0 + i]), 32'h100 + 32'(i));
      check("t1_rd_idle", 32'(bus.sdram_rd), 0);
      for (int i = 0; i < 4; i++)
         pop_word(16'h0100 + 16'(i), $sformatf("t1_pop%0d", i));
      step();
      check("t1_done_pulse", 32'(done), 1);
      step();
      check("t1_done_clear", 32'(done), 0);
      check("t1_busy_fall", 32'(busy), 0);
      check("t1_empty_valid", 32'(bus.sample_valid), 0);
      check("t1_empty_data", 32'(bus.sample_data), 0);

      // Watermark: 16 reads fill the FIFO, refill only at count 8
      i0 = issued.size();
      a0 = n_acks;
      do_start(25'h2000, 25'd40, 1'b0);
      wait_acks(a0 + 16, 300, "t2_acks16");
      repeat (20) step();
      check("t2_nreads_full", 32'(issued.size() - i0), 16);
      check("t2_rd_refill", 32'(bus.sdram_rd), 0);
      check("t2_busy", 32'(busy), 1);
      for (int i = 0; i < 7; i++)
         pop_word(16'h2000 + 16'(i), $sformatf("t2_pop%0d", i));
      repeat (6) step();
      check("t2_no_read_at9", 32'(issued.size() - i0), 16);
      check("t2_rd_low_at9", 32'(bus.sdram_rd), 0);
      pop_word(16'h2007, "t2_pop7");
      wait_rd(10, "t2_refetch_rd");
      check("t2_refetch_addr", 32'(bus.sdram_addr), 32'h2010);
      do_stop();
      check("t2_stop_busy", 32'(busy), 0);
      check("t2_stop_rd", 32'(bus.sdram_rd), 0);
      check("t2_stop_valid", 32'(bus.sample_valid), 0);

      // Wait handling: cancelled read is reissued at the same address
      i0 = issued.size();
      a0 = n_acks;
      do_start(25'h300, 25'd3, 1'b0);
      wait_rd(5, "t3_first_rd");
      bus.sdram_wait = 1'b1;
      step();
      check("t3_rd_drop", 32'(bus.sdram_rd), 0);
      check("t3_addr_hold", 32'(bus.sdram_addr), 32'h300);
      step();
      step();
      check("t3_rd_held_low", 32'(bus.sdram_rd), 0);
      bus.sdram_wait = 1'b0;
      wait_acks(a0 + 3, 60, "t3_acks");
      step();
      step();
      check("t3_nissues", 32'(issued.size() - i0), 4);
      check("t3_issue0", 32'(issued[i0]), 32'h300);
      check("t3_issue1", 32'(issued[i0 + 1]), 32'h300);
      check("t3_issue2", 32'(issued[i0 + 2]), 32'h301);
      check("t3_issue3", 32'(issued[i0 + 3]), 32'h302);
      for (int i = 0; i < 3; i++)
         pop_word(16'h0300 + 16'(i), $sformatf("t3_pop%0d", i));
      check("t3_no_extra", 32'(bus.sample_valid), 0);
      wait_idle(6, "t3_idle");

      // Loop with address wrap
      i0 = issued.size();
      a0 = n_acks;
      d0 = done_cnt;
      exp_seq[0] = 25'h1FFFFFE;
      exp_seq[1] = 25'h1FFFFFF;
      exp_seq[2] = 25'h0000000;
      exp_seq[3] = 25'h1FFFFFE;
      exp_seq[4] = 25'h1FFFFFF;
      exp_seq[5] = 25'h0000000;
      do_start(25'h1FFFFFE, 25'd3, 1'b1);
      wait_acks(a0 + 6, 100, "t4_acks");
      for (int i = 0; i < 6; i++)
         check($sformatf("t4_addr%0d", i), 32'(issued[i0 + i]), 32'(exp_seq[i]));
      pop_word(16'hFFFE, "t4_pop0");
      pop_word(16'hFFFF, "t4_pop1");
      pop_word(16'h0000, "t4_pop2");
      pop_word(16'hFFFE, "t4_pop3");
      check("t4_busy", 32'(busy), 1);
      check("t4_no_done", 32'(done_cnt - d0), 0);
      do_stop();

      // Underrun, stop flush, late ack ignored, restart clears underrun
      a0 = n_acks;
      do_start(25'h400, 25'd8, 1'b0);
      bus.sample_req = 1'b1;
      step();
      bus.sample_req = 1'b0;
      check("t5_underrun_set", 32'(underrun), 1);
      check("t5_underrun_data", 32'(bus.sample_data), 0);
      check("t5_underrun_valid", 32'(bus.sample_valid), 0);
      wait_acks(a0 + 2, 40, "t5_acks");
      step();
      check("t5_fifo_nonempty", 32'(bus.sample_valid), 1);
      check("t5_head", 32'(bus.sample_data), 32'h0400);
      ack_en = 1'b0;
      do_stop();
      check("t5_stop_busy", 32'(busy), 0);
      check("t5_stop_rd", 32'(bus.sdram_rd), 0);
      check("t5_stop_flush", 32'(bus.sample_valid), 0);
      check("t5_underrun_sticky", 32'(underrun), 1);
      inj_req++;
      repeat (3) step();
      check("t5_late_ac_ignored", 32'(bus.sample_valid), 0);
      check("t5_late_ac_data", 32'(bus.sample_data), 0);
      ack_en = 1'b1;
      a0 = n_acks;
      do_start(25'h500, 25'd1, 1'b0);
      check("t5_underrun_clear", 32'(underrun), 0);
      wait_acks(a0 + 1, 20, "t5_restart_ack");
      step();
      pop_word(16'h0500, "t5_pop");
      wait_idle(6, "t5_idle");

      // Asynchronous reset while a read is pending
      ack_en = 1'b0;
      do_start(25'h600, 25'd4, 1'b0);
      wait_rd(5, "t6_rd");
      #2;
      reset = 1'b1;
      #1;
      check("t6_rst_rd", 32'(bus.sdram_rd), 0);
      check("t6_rst_addr", 32'(bus.sdram_addr), 0);
      check("t6_rst_busy", 32'(busy), 0);
      check("t6_rst_valid", 32'(bus.sample_valid), 0);
      check("t6_rst_data", 32'(bus.sample_data), 0);
      check("t6_rst_done", 32'(done), 0);
      reset = 1'b0;
      step();
      ack_en = 1'b1;
      i0 = issued.size();
      do_start(25'h0, 25'd0, 1'b0);
      check("t6_zero_done", 32'(done), 1);
      check("t6_zero_busy", 32'(busy), 1);
      check("t6_zero_rd", 32'(bus.sdram_rd), 0);
      step();
      check("t6_zero_done_clear", 32'(done), 0);
      check("t6_zero_idle", 32'(busy), 0);
      repeat (3) step();
      check("t6_no_read", 32'(issued.size() - i0), 0);

      $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
      $finish;
   end

endmodule
